// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: widths and FSM state encodings.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;
   localparam int BYTE_W      = 8;
   localparam int WORD_W      = 32;
   localparam int LEN_W       = 16;
   localparam int IMEM_ADDR_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM   = 3'd4,
`endif
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts accepted bytes in MSB-first; word_done marks the 4th byte, with the
// completed word (including that byte) presented combinationally on word.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic              word_done,
   output logic [WORD_W-1:0] word
);
   logic [WORD_W-BYTE_W-1:0] shift_q;
   logic [1:0]               idx_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else if (en) begin
         shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
         idx_q   <= idx_q + 2'd1;
      end
   end

   assign word_done = en && (idx_q == 2'd3);
   assign word      = {shift_q, byte_in};
endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> word writes; holds cpu_ce low until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte after the data.
//   state  | meaning
//   IDLE   | waiting for start
//   LEN_HI | expecting word-count high byte
//   LEN_LO | expecting word-count low byte, range check
//   DATA   | packing bytes, writing words
//   CSUM   | expecting checksum byte (checksum build only)
//   DONE   | image loaded, CPU enabled from the next cycle
//   ERR    | load rejected, CPU held
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_ce,
   output logic              busy,
   output logic              done,
   output logic              err
);
   state_t              state_q, state_d, data_end_st;
   logic                accept, in_data, pack_en, word_done, last_word, start_go;
   logic [WORD_W-1:0]   packed_word;
   logic [BYTE_W-1:0]   len_hi_q;
   logic [LEN_W-1:0]    len_w, words_left_q;
   logic [ADDR_W-1:0]   next_addr_q;

   assign accept    = rx_valid && rx_ready;
   assign in_data   = (state_q == ST_DATA);
   assign pack_en   = accept && in_data;
   assign len_w     = {len_hi_q, rx_data};
   assign last_word = word_done && (words_left_q == LEN_W'(1));
   assign start_go  = (state_d == ST_LEN_HI) && (state_q != ST_LEN_HI);

   imem_loader_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (!in_data),
      .en        (pack_en),
      .byte_in   (rx_data),
      .word_done (word_done),
      .word      (packed_word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] sum_q;
   logic              csum_ok;

   assign data_end_st = ST_CSUM;
   assign csum_ok     = (BYTE_W'(sum_q + rx_data) == '0);

   always_ff @(posedge clk) begin
      if (rst || start_go) sum_q <= '0;
      else if (pack_en)    sum_q <= sum_q + rx_data;
   end
`else
   assign data_end_st = ST_DONE;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LEN_HI;
         ST_LEN_HI: if (accept) state_d = ST_LEN_LO;
         ST_LEN_LO: begin
            if (accept) begin
               if (len_w == '0)                     state_d = data_end_st;
               else if (len_w > LEN_W'(MAX_WORDS))  state_d = ST_ERR;
               else                                 state_d = ST_DATA;
            end
         end
         ST_DATA: if (last_word) state_d = data_end_st;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: if (accept) state_d = csum_ok ? ST_DONE : ST_ERR;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      case (state_q)
         ST_LEN_HI, ST_LEN_LO, ST_DATA: busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: busy = 1'b1;
`endif
         default: busy = 1'b0;
      endcase
      rx_ready = busy;
   end

   // Status flags follow the next state so done/err rise with DONE/ERR entry; cpu_ce lags one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         next_addr_q  <= '0;
         words_left_q <= '0;
         len_hi_q     <= '0;
         cpu_ce       <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         imem_we <= word_done;
         done    <= (state_d == ST_DONE);
         err     <= (state_d == ST_ERR);
         cpu_ce  <= (state_q == ST_DONE) && (state_d == ST_DONE);
         if (start_go)
            next_addr_q <= '0;
         if (accept && (state_q == ST_LEN_HI))
            len_hi_q <= rx_data;
         if (accept && (state_q == ST_LEN_LO))
            words_left_q <= len_w;
         if (word_done) begin
            imem_waddr   <= next_addr_q;
            imem_wdata   <= packed_word;
            next_addr_q  <= next_addr_q + ADDR_W'(1);
            words_left_q <= words_left_q - LEN_W'(1);
         end
      end
   end
endmodule
